// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the two-master AHB-Lite slave-port arbiter.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    typedef struct packed {
        logic       write;
        logic [2:0] size;
    } ahb_ctrl_t;

    function automatic owner_e own_enc(input int idx);
        return (idx == 0) ? OWN_M0 : OWN_M1;
    endfunction

endpackage

// File: rtl/ahb_arb_in_stage.sv
// Per-master input stage: holds a losing address phase and stalls the master
// until it is granted; also steers the shared slave response to its owner.
module ahb_arb_in_stage
    import ahb_arb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          cpu_clk,
    input  logic          pg_reset_b,
    input  logic [AW-1:0] haddr,
    input  logic          req,
    input  ahb_ctrl_t     ctrl,
    input  logic          grant,
    input  logic          dp_mine,
    input  logic          s_hready,
    input  logic          s_hresp,
    output logic          cand,
    output logic [AW-1:0] cand_addr,
    output ahb_ctrl_t     cand_ctrl,
    output logic          hready,
    output logic          hresp,
    output logic          pend_vld
);

    logic [AW-1:0] pend_addr;
    ahb_ctrl_t     pend_ctrl;
    logic          req_live;

    assign hready    = pend_vld ? 1'b0 : (dp_mine ? s_hready : 1'b1);
    assign hresp     = dp_mine & s_hresp;
    assign req_live  = req & hready;
    // A held request masks the live bus: the master is stalled so it cannot issue another.
    assign cand      = pend_vld | req_live;
    assign cand_addr = pend_vld ? pend_addr : haddr;
    assign cand_ctrl = pend_vld ? pend_ctrl : ctrl;

    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_ctrl <= '0;
        end else if (grant) begin
            pend_vld  <= 1'b0;
        end else if (req_live) begin
            pend_vld  <= 1'b1;
            pend_addr <= haddr;
            pend_ctrl <= ctrl;
        end
    end

endmodule

// File: rtl/ahb_lite_2m1s_arb.sv
// Two AHB-Lite masters (E902 iahbl = M0, biu = M1) sharing one AHB-Lite slave;
// uncontended requests pass through with no added latency.
module ahb_lite_2m1s_arb
    import ahb_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter bit RR = 1'b1
) (
    input  logic          cpu_clk,
    input  logic          pg_reset_b,
    input  logic [AW-1:0] m0_haddr,
    input  logic [1:0]    m0_htrans,
    input  logic          m0_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [DW-1:0] m0_hwdata,
    output logic [DW-1:0] m0_hrdata,
    output logic          m0_hready,
    output logic          m0_hresp,
    input  logic [AW-1:0] m1_haddr,
    input  logic [1:0]    m1_htrans,
    input  logic          m1_hwrite,
    input  logic [2:0]    m1_hsize,
    input  logic [DW-1:0] m1_hwdata,
    output logic [DW-1:0] m1_hrdata,
    output logic          m1_hready,
    output logic          m1_hresp,
    output logic          s_hsel,
    output logic [AW-1:0] s_haddr,
    output logic [1:0]    s_htrans,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [DW-1:0] s_hwdata,
    input  logic [DW-1:0] s_hrdata,
    input  logic          s_hready,
    input  logic          s_hresp
);

    localparam int NUM_M = 2;

    logic [NUM_M-1:0][AW-1:0] m_haddr, cand_addr;
    ahb_ctrl_t [NUM_M-1:0]    m_ctrl, cand_ctrl;
    logic [NUM_M-1:0]         m_req, cand, grant, dp_mine, hready, hresp, pend_vld;

    owner_e        dp_owner, dp_owner_nxt;
    logic          rr_last_m1;
    logic [AW-1:0] haddr_q;
    ahb_ctrl_t     ctrl_q;
    logic          unused_htrans;

    assign m_haddr       = {m1_haddr, m0_haddr};
    assign m_req         = {m1_htrans[1], m0_htrans[1]};
    assign m_ctrl[0]     = '{write: m0_hwrite, size: m0_hsize};
    assign m_ctrl[1]     = '{write: m1_hwrite, size: m1_hsize};
    assign unused_htrans = m0_htrans[0] ^ m1_htrans[0];

    for (genvar i = 0; i < NUM_M; i++) begin : g_in
        assign dp_mine[i] = (dp_owner == own_enc(i));

        ahb_arb_in_stage #(.AW(AW)) u_in_stage (
            .cpu_clk    (cpu_clk),
            .pg_reset_b (pg_reset_b),
            .haddr      (m_haddr[i]),
            .req        (m_req[i]),
            .ctrl       (m_ctrl[i]),
            .grant      (grant[i]),
            .dp_mine    (dp_mine[i]),
            .s_hready   (s_hready),
            .s_hresp    (s_hresp),
            .cand       (cand[i]),
            .cand_addr  (cand_addr[i]),
            .cand_ctrl  (cand_ctrl[i]),
            .hready     (hready[i]),
            .hresp      (hresp[i]),
            .pend_vld   (pend_vld[i])
        );
    end

    // Contention: round-robin favours whoever was not granted last; fixed mode favours M0.
    always_comb begin
        grant = '0;
        if (s_hready) begin
            if (cand[0] && cand[1]) begin
                if (RR && !rr_last_m1) grant[1] = 1'b1;
                else                   grant[0] = 1'b1;
            end else begin
                grant = cand;
            end
        end
    end

    always_comb begin
        dp_owner_nxt = OWN_NONE;
        if (grant[0])      dp_owner_nxt = OWN_M0;
        else if (grant[1]) dp_owner_nxt = OWN_M1;
    end

    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            dp_owner   <= OWN_NONE;
            rr_last_m1 <= 1'b1;
        end else if (s_hready) begin
            dp_owner <= dp_owner_nxt;
            if (|grant) rr_last_m1 <= grant[1];
        end
    end

    // Idle cycles keep presenting the last address/control.
    always_ff @(posedge cpu_clk or negedge pg_reset_b) begin
        if (!pg_reset_b) begin
            haddr_q <= '0;
            ctrl_q  <= '0;
        end else begin
            haddr_q <= s_haddr;
            ctrl_q  <= '{write: s_hwrite, size: s_hsize};
        end
    end

    always_comb begin
        s_htrans = HTRANS_IDLE;
        s_haddr  = haddr_q;
        s_hwrite = ctrl_q.write;
        s_hsize  = ctrl_q.size;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant[i]) begin
                s_htrans = HTRANS_NONSEQ;
                s_haddr  = cand_addr[i];
                s_hwrite = cand_ctrl[i].write;
                s_hsize  = cand_ctrl[i].size;
            end
        end
    end

    assign s_hsel = s_htrans[1];

    always_comb begin
        s_hwdata = '0;
        case (dp_owner)
            OWN_M0:  s_hwdata = m0_hwdata;
            OWN_M1:  s_hwdata = m1_hwdata;
            default: s_hwdata = '0;
        endcase
    end

    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
    assign m0_hready = hready[0];
    assign m1_hready = hready[1];
    assign m0_hresp  = hresp[0];
    assign m1_hresp  = hresp[1];

    always_ff @(posedge cpu_clk) begin
        if (pg_reset_b) assert (!(|(dp_mine & pend_vld)));
    end

endmodule

// File: tb/tb_ahb_lite_2m1s_arb.sv
// Bench for ahb_lite_2m1s_arb: cycle vector table through a scoreboard queue,
// plus hand sequences for reset-in-flight and back-to-back streaming.
module tb_ahb_lite_2m1s_arb;

    localparam logic [1:0]  NS  = 2'b10;
    localparam logic [1:0]  ID  = 2'b00;
    localparam logic [31:0] WD0 = 32'h0A0A_0A0A;
    localparam logic [31:0] WD1 = 32'hDEAD_BEEF;

    logic        cpu_clk, pg_reset_b;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, s_hrdata;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic        s_hready, s_hresp;

    logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp, s_hsel, s_hwrite;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;

    logic [31:0] fp_m0_hrdata, fp_m1_hrdata, fp_s_haddr, fp_s_hwdata;
    logic        fp_m0_hready, fp_m1_hready, fp_m0_hresp, fp_m1_hresp, fp_s_hsel, fp_s_hwrite;
    logic [1:0]  fp_s_htrans;
    logic [2:0]  fp_s_hsize;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_lite_2m1s_arb #(.AW(32), .DW(32), .RR(1'b1)) dut (
        .cpu_clk(cpu_clk), .pg_reset_b(pg_reset_b),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready),
        .s_hresp(s_hresp)
    );

    ahb_lite_2m1s_arb #(.AW(32), .DW(32), .RR(1'b0)) dut_fp (
        .cpu_clk(cpu_clk), .pg_reset_b(pg_reset_b),
        .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hwdata(m0_hwdata), .m0_hrdata(fp_m0_hrdata), .m0_hready(fp_m0_hready), .m0_hresp(fp_m0_hresp),
        .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hwdata(m1_hwdata), .m1_hrdata(fp_m1_hrdata), .m1_hready(fp_m1_hready), .m1_hresp(fp_m1_hresp),
        .s_hsel(fp_s_hsel), .s_haddr(fp_s_haddr), .s_htrans(fp_s_htrans), .s_hwrite(fp_s_hwrite),
        .s_hsize(fp_s_hsize), .s_hwdata(fp_s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready),
        .s_hresp(s_hresp)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        rdy, rsp;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_r0, e_r1, e_p0, e_p1;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(logic [1:0] t0, logic [31:0] a0, logic [1:0] t1, logic [31:0] a1,
                                logic rdy, logic rsp, logic [1:0] e_trans, logic [31:0] e_addr,
                                logic e_r0, logic e_r1, logic e_p0, logic e_p1, logic [31:0] e_wd);
        vec_t v;
        v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1; v.rdy = rdy; v.rsp = rsp;
        v.e_trans = e_trans; v.e_addr = e_addr;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_p0 = e_p0; v.e_p1 = e_p1; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        m0_htrans = ID; m1_htrans = ID; m0_haddr = '0; m1_haddr = '0;
        s_hready = 1'b1; s_hresp = 1'b0;
    endtask

    int cnt_rr0, cnt_rr1, cnt_fp0, cnt_fp1, alt_err, prev_g, g;

    initial begin
        m0_hwrite = 1'b0; m0_hsize = 3'd2; m0_hwdata = WD0;
        m1_hwrite = 1'b1; m1_hsize = 3'd2; m1_hwdata = WD1;
        s_hrdata  = '0;
        drive_idle();
        s_hresp    = 1'b1;
        pg_reset_b = 1'b0;

        // T2 first (needs the post-reset priority), then T1, T3, T4 incl. pipelined request in error cycle 2
        vecs.push_back(mk(NS, 32'h10,  NS, 32'h2000_0010, 1, 0, NS, 32'h10,         1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(ID, 32'h0,   NS, 32'h2000_0010, 1, 0, NS, 32'h2000_0010, 1, 0, 0, 0, WD0));
        vecs.push_back(mk(ID, 32'h0,   ID, 32'h0,         1, 0, ID, 32'h2000_0010, 1, 1, 0, 0, WD1));
        vecs.push_back(mk(NS, 32'h100, ID, 32'h0,         1, 0, NS, 32'h100,       1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(ID, 32'h0,   ID, 32'h0,         1, 0, ID, 32'h100,       1, 1, 0, 0, WD0));
        vecs.push_back(mk(ID, 32'h0,   NS, 32'h2000_0040, 1, 0, NS, 32'h2000_0040, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(NS, 32'h200, ID, 32'h0,         0, 0, ID, 32'h2000_0040, 1, 0, 0, 0, WD1));
        vecs.push_back(mk(NS, 32'h200, ID, 32'h0,         0, 0, ID, 32'h2000_0040, 0, 0, 0, 0, WD1));
        vecs.push_back(mk(NS, 32'h200, ID, 32'h0,         0, 0, ID, 32'h2000_0040, 0, 0, 0, 0, WD1));
        vecs.push_back(mk(NS, 32'h200, ID, 32'h0,         1, 0, NS, 32'h200,       0, 1, 0, 0, WD1));
        vecs.push_back(mk(ID, 32'h0,   NS, 32'h2000_0080, 0, 1, ID, 32'h200,       0, 1, 1, 0, WD0));
        vecs.push_back(mk(NS, 32'h300, NS, 32'h2000_0080, 1, 1, NS, 32'h2000_0080, 1, 0, 1, 0, WD0));
        vecs.push_back(mk(ID, 32'h0,   ID, 32'h0,         1, 0, NS, 32'h300,       0, 1, 0, 0, WD1));
        vecs.push_back(mk(ID, 32'h0,   ID, 32'h0,         1, 0, ID, 32'h300,       1, 1, 0, 0, WD0));

        repeat (2) @(posedge cpu_clk);
        #1;
        chk("rst_htrans", s_htrans, ID);
        chk("rst_hsel",   s_hsel, 0);
        chk("rst_m0_rdy", m0_hready, 1);
        chk("rst_m1_rdy", m1_hready, 1);
        chk("rst_m0_rsp", m0_hresp, 0);
        chk("rst_m1_rsp", m1_hresp, 0);
        pg_reset_b = 1'b1;
        s_hresp    = 1'b0;

        foreach (vecs[i]) begin
            @(posedge cpu_clk); #1;
            m0_htrans = vecs[i].t0; m0_haddr = vecs[i].a0;
            m1_htrans = vecs[i].t1; m1_haddr = vecs[i].a1;
            s_hready  = vecs[i].rdy; s_hresp = vecs[i].rsp;
            s_hrdata  = $urandom;
            sb.push_back(vecs[i]);
            @(negedge cpu_clk);
            begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("v%0d_htrans", i), s_htrans, e.e_trans);
                chk($sformatf("v%0d_hsel", i),   s_hsel, e.e_trans[1]);
                chk($sformatf("v%0d_haddr", i),  s_haddr, e.e_addr);
                chk($sformatf("v%0d_m0_rdy", i), m0_hready, e.e_r0);
                chk($sformatf("v%0d_m1_rdy", i), m1_hready, e.e_r1);
                chk($sformatf("v%0d_m0_rsp", i), m0_hresp, e.e_p0);
                chk($sformatf("v%0d_m1_rsp", i), m1_hresp, e.e_p1);
                chk($sformatf("v%0d_hwdata", i), s_hwdata, e.e_wd);
                chk($sformatf("v%0d_m0_rdata", i), m0_hrdata, s_hrdata);
                chk($sformatf("v%0d_m1_rdata", i), m1_hrdata, s_hrdata);
            end
        end

        // T6: M0 owns the data phase (slave stalled), M1 pending, then reset
        @(posedge cpu_clk); #1;
        m0_htrans = NS; m0_haddr = 32'h400; m1_htrans = ID; s_hready = 1'b1;
        @(posedge cpu_clk); #1;
        m0_htrans = ID; m1_htrans = NS; m1_haddr = 32'h2000_0200; s_hready = 1'b0;
        @(posedge cpu_clk); #1;
        chk("t6_pre_m1_rdy", m1_hready, 0);
        chk("t6_pre_m0_rdy", m0_hready, 0);
        m0_htrans = ID; m1_htrans = ID; s_hresp = 1'b1;
        pg_reset_b = 1'b0;
        #1;
        chk("t6_htrans", s_htrans, ID);
        chk("t6_m0_rdy", m0_hready, 1);
        chk("t6_m1_rdy", m1_hready, 1);
        chk("t6_m0_rsp", m0_hresp, 0);
        chk("t6_m1_rsp", m1_hresp, 0);
        @(posedge cpu_clk); #1;
        pg_reset_b = 1'b1; s_hready = 1'b1; s_hresp = 1'b0;
        m1_htrans = NS; m1_haddr = 32'h2000_0100;
        @(negedge cpu_clk);
        chk("t6_new_htrans", s_htrans, NS);
        chk("t6_new_haddr",  s_haddr, 32'h2000_0100);
        chk("t6_new_m1_rdy", m1_hready, 1);
        @(posedge cpu_clk); #1;
        m1_htrans = ID;
        @(negedge cpu_clk);
        chk("t6_dp_m1_rdy",  m1_hready, 1);
        chk("t6_dp_hwdata",  s_hwdata, WD1);
        chk("t6_dp_htrans",  s_htrans, ID);

        // T5: both masters stream NONSEQ for 20 cycles
        cnt_rr0 = 0; cnt_rr1 = 0; cnt_fp0 = 0; cnt_fp1 = 0; alt_err = 0; prev_g = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge cpu_clk); #1;
            m0_htrans = NS; m0_haddr = 32'h1000;
            m1_htrans = NS; m1_haddr = 32'h2000_1000;
            @(negedge cpu_clk);
            if (s_htrans == NS) begin
                g = s_haddr[29] ? 1 : 0;
                if (g == prev_g) alt_err++;
                prev_g = g;
                if (g == 1) cnt_rr1++; else cnt_rr0++;
            end
            if (fp_s_htrans == NS) begin
                if (fp_s_haddr[29]) cnt_fp1++; else cnt_fp0++;
            end
        end
        chk("t5_rr_m0_cnt", cnt_rr0, 10);
        chk("t5_rr_m1_cnt", cnt_rr1, 10);
        chk("t5_rr_alt",    alt_err, 0);
        chk("t5_fp_m0_cnt", cnt_fp0, 20);
        chk("t5_fp_m1_cnt", cnt_fp1, 0);

        @(posedge cpu_clk); #1;
        drive_idle();
        repeat (2) @(posedge cpu_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
